// File: rtl/wbs_router_pkg.sv
// Shared types for the Wishbone single-master router: FSM states, error codes
// and a helper that sizes slave-index fields.
package wbs_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_DECODE  = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_code_e;

    localparam int ERR_CNT_W = 16;

    // A single slave still needs a one-bit index field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wbs_addr_decode.sv
// Combinational address decoder: inclusive range compare per slave followed
// by a lowest-index-wins priority encoder.
module wbs_addr_decode
    import wbs_router_pkg::*;
#(
    parameter int                           NUM_SLAVES = 14,
    parameter int                           ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_ADDR = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_HIGH = '0,
    parameter int                           IDX_W      = idx_width(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0]     adr_i,
    output logic [NUM_SLAVES-1:0] hit_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  miss_o,
    output logic [ADDR_W-1:0]     base_o
);

    logic [NUM_SLAVES-1:0] raw_hit;

    always_comb begin
        raw_hit = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            raw_hit[i] = (adr_i >= SLAVE_ADDR[i*ADDR_W +: ADDR_W]) &&
                         (adr_i <= SLAVE_HIGH[i*ADDR_W +: ADDR_W]);
        end
    end

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit_o  = '0;
        idx_o  = '0;
        base_o = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (raw_hit[i]) begin
                hit_o    = '0;
                hit_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
                base_o   = SLAVE_ADDR[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign miss_o = ~|raw_hit;

endmodule

// File: rtl/wbs_router.sv
// Wishbone single-master to N-slave router with registered responses,
// per-transfer timeout and sticky bus-error capture.
module wbs_router
    import wbs_router_pkg::*;
#(
    parameter int                           NUM_SLAVES = 14,
    parameter int                           ADDR_W     = 32,
    parameter int                           DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_ADDR = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_HIGH = '0,
    parameter int                           REL_ADDR   = 1,
    parameter int                           TIMEOUT    = 10
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         wbm_cyc_i,
    input  logic                         wbm_stb_i,
    input  logic                         wbm_we_i,
    input  logic [DATA_W/8-1:0]          wbm_sel_i,
    input  logic [ADDR_W-1:0]            wbm_adr_i,
    input  logic [DATA_W-1:0]            wbm_dat_i,
    output logic [DATA_W-1:0]            wbm_dat_o,
    output logic                         wbm_ack_o,
    output logic                         wbm_err_o,
    output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]        wbs_stb_o,
    output logic                         wbs_we_o,
    output logic [DATA_W/8-1:0]          wbs_sel_o,
    output logic [DATA_W-1:0]            wbs_dat_o,
    output logic [ADDR_W-1:0]            wbs_adr_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
    output logic [1:0]                   err_code_o,
    output logic [ADDR_W-1:0]            err_adr_o,
    output logic [ERR_CNT_W-1:0]         err_cnt_o,
    input  logic                         err_clr_i
);

    localparam int IDX_W = idx_width(NUM_SLAVES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int SEL_W = DATA_W / 8;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0] slv_q, slv_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  we_q, we_d;
    logic [SEL_W-1:0]      bsel_q, bsel_d;
    logic [DATA_W-1:0]     wdat_q, wdat_d;
    logic [ADDR_W-1:0]     sadr_q, sadr_d;
    logic [ADDR_W-1:0]     madr_q, madr_d;
    logic [DATA_W-1:0]     rdat_q, rdat_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [ADDR_W-1:0]     err_adr_q, err_adr_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [NUM_SLAVES-1:0] dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_miss;
    logic [ADDR_W-1:0]     dec_base;
    logic                  req, slv_ack, tmo;
    logic [DATA_W-1:0]     slv_dat;
    logic                  err_evt;
    logic [1:0]            err_evt_code;
    logic [ADDR_W-1:0]     err_evt_adr;

    wbs_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLAVE_ADDR (SLAVE_ADDR),
        .SLAVE_HIGH (SLAVE_HIGH),
        .IDX_W      (IDX_W)
    ) u_decode (
        .adr_i  (wbm_adr_i),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx),
        .miss_o (dec_miss),
        .base_o (dec_base)
    );

    assign req     = wbm_cyc_i & wbm_stb_i;
    assign slv_ack = |(wbs_ack_i & slv_q);
    assign tmo     = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        slv_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) slv_dat = wbs_dat_i[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = dec_miss ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                if (!wbm_cyc_i)         state_d = ST_IDLE;
                else if (slv_ack || tmo) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are gated by state so an abort or reset drops them at once.
    always_comb begin
        wbs_cyc_o = (state_q == ST_WAIT) ? slv_q : '0;
        wbs_stb_o = wbs_cyc_o;
    end

    always_comb begin
        slv_d        = slv_q;
        idx_d        = idx_q;
        we_d         = we_q;
        bsel_d       = bsel_q;
        wdat_d       = wdat_q;
        sadr_d       = sadr_q;
        madr_d       = madr_q;
        rdat_d       = rdat_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        err_evt      = 1'b0;
        err_evt_code = ERR_NONE;
        err_evt_adr  = '0;
        cnt_d        = (state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;

        if (state_q == ST_IDLE && req) begin
            if (dec_miss) begin
                err_d        = 1'b1;
                err_evt      = 1'b1;
                err_evt_code = ERR_DECODE;
                err_evt_adr  = wbm_adr_i;
            end else begin
                slv_d  = dec_hit;
                idx_d  = dec_idx;
                we_d   = wbm_we_i;
                bsel_d = wbm_sel_i;
                wdat_d = wbm_dat_i;
                madr_d = wbm_adr_i;
                sadr_d = (REL_ADDR != 0) ? wbm_adr_i - dec_base : wbm_adr_i;
            end
        end else if (state_q == ST_WAIT && wbm_cyc_i) begin
            if (slv_ack) begin
                ack_d  = 1'b1;
                rdat_d = slv_dat;
            end else if (tmo) begin
                err_d        = 1'b1;
                err_evt      = 1'b1;
                err_evt_code = ERR_TIMEOUT;
                err_evt_adr  = madr_q;
            end
        end

        // A new error outranks a simultaneous clear, restarting the count at one.
        err_code_d = err_code_q;
        err_adr_d  = err_adr_q;
        err_cnt_d  = err_cnt_q;
        if (err_evt) begin
            err_code_d = err_evt_code;
            err_adr_d  = err_evt_adr;
            if (err_clr_i)              err_cnt_d = ERR_CNT_W'(1);
            else if (err_cnt_q != '1)   err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end else if (err_clr_i) begin
            err_code_d = ERR_NONE;
            err_adr_d  = '0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q      <= '0;
            slv_q      <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            bsel_q     <= '0;
            wdat_q     <= '0;
            sadr_q     <= '0;
            madr_q     <= '0;
            rdat_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_adr_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            slv_q      <= slv_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            bsel_q     <= bsel_d;
            wdat_q     <= wdat_d;
            sadr_q     <= sadr_d;
            madr_q     <= madr_d;
            rdat_q     <= rdat_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_adr_q  <= err_adr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign wbm_dat_o  = rdat_q;
    assign wbm_ack_o  = ack_q;
    assign wbm_err_o  = err_q;
    assign wbs_we_o   = we_q;
    assign wbs_sel_o  = bsel_q;
    assign wbs_dat_o  = wdat_q;
    assign wbs_adr_o  = sadr_q;
    assign err_code_o = err_code_q;
    assign err_adr_o  = err_adr_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_wbs_router.sv
// Directed bench for wbs_router: six slaves with an overlapping pair, checks
// routing, relative addressing, timeout, abort, reset and error-counter paths.
module tb_wbs_router;

    localparam int NS = 6;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [NS*AW-1:0] BASES = {32'h3000, 32'h2000, 32'h0040, 32'h0100, 32'h1000, 32'h0000};
    localparam logic [NS*AW-1:0] HIGHS = {32'h3FFF, 32'h2FFF, 32'h007F, 32'h01FF, 32'h1FFF, 32'h00FF};

    logic              clk = 1'b0;
    logic              rst;
    logic              cyc, stb, we, clr;
    logic [DW/8-1:0]   sel;
    logic [AW-1:0]     adr;
    logic [DW-1:0]     wdat;
    logic [DW-1:0]     mdat;
    logic              mack, merr;
    logic [NS-1:0]     scyc, sstb;
    logic              swe;
    logic [DW/8-1:0]   ssel;
    logic [DW-1:0]     sdat;
    logic [AW-1:0]     sadr;
    logic [NS*DW-1:0]  sdat_i;
    logic [NS-1:0]     sack;
    logic [1:0]        ecode;
    logic [AW-1:0]     eadr;
    logic [15:0]       ecnt;

    int total = 0;
    int bad   = 0;

    wbs_router #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SLAVE_ADDR (BASES),
        .SLAVE_HIGH (HIGHS),
        .REL_ADDR   (1),
        .TIMEOUT    (10)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbm_cyc_i  (cyc),
        .wbm_stb_i  (stb),
        .wbm_we_i   (we),
        .wbm_sel_i  (sel),
        .wbm_adr_i  (adr),
        .wbm_dat_i  (wdat),
        .wbm_dat_o  (mdat),
        .wbm_ack_o  (mack),
        .wbm_err_o  (merr),
        .wbs_cyc_o  (scyc),
        .wbs_stb_o  (sstb),
        .wbs_we_o   (swe),
        .wbs_sel_o  (ssel),
        .wbs_dat_o  (sdat),
        .wbs_adr_o  (sadr),
        .wbs_dat_i  (sdat_i),
        .wbs_ack_i  (sack),
        .err_code_o (ecode),
        .err_adr_o  (eadr),
        .err_cnt_o  (ecnt),
        .err_clr_i  (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [AW-1:0] a, input logic w);
        cyc = 1'b1;
        stb = 1'b1;
        we  = w;
        adr = a;
    endtask

    task automatic idle_master();
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; clr = 1'b0;
        sel = '0; adr = '0; wdat = '0; sdat_i = '0; sack = '0;
        tick(); tick();
        chk("rst_ack", mack, 0);
        chk("rst_err", merr, 0);
        chk("rst_cyc", scyc, 0);
        chk("rst_code", ecode, 0);
        chk("rst_cnt", ecnt, 0);
        chk("rst_dat", mdat, 0);
        rst = 1'b0;
        tick();

        // Read slave 2, ack on third WAIT cycle
        sel = 4'hF;
        start(32'h104, 1'b0);
        tick();
        chk("rd2_cyc1", scyc, 6'h04);
        chk("rd2_stb1", sstb, 6'h04);
        chk("rd2_adr", sadr, 32'h004);
        tick();
        chk("rd2_cyc2", scyc, 6'h04);
        tick();
        chk("rd2_cyc3", scyc, 6'h04);
        chk("rd2_noack", mack, 0);
        sack = 6'b000100;
        sdat_i[2*DW +: DW] = 32'hDEADBEEF;
        tick();
        chk("rd2_ack", mack, 1);
        chk("rd2_dat", mdat, 32'hDEADBEEF);
        chk("rd2_cyc_drop", scyc, 0);
        sack = '0;
        idle_master();
        tick();
        chk("rd2_ack_pulse", mack, 0);

        // Decode miss
        start(32'hFFFF0000, 1'b0);
        tick();
        chk("miss_err", merr, 1);
        chk("miss_ack", mack, 0);
        chk("miss_cyc", scyc, 0);
        chk("miss_code", ecode, 2'b01);
        chk("miss_eadr", eadr, 32'hFFFF0000);
        chk("miss_cnt", ecnt, 1);
        idle_master();
        tick();
        chk("miss_err_pulse", merr, 0);
        chk("miss_code_sticky", ecode, 2'b01);

        // Write to slave 4, never acked: timeout
        sel = 4'h3; wdat = 32'h12345678;
        start(32'h2010, 1'b1);
        tick();
        chk("wr4_cyc", scyc, 6'h10);
        chk("wr4_adr", sadr, 32'h10);
        chk("wr4_we", swe, 1);
        chk("wr4_sel", ssel, 4'h3);
        chk("wr4_dat", sdat, 32'h12345678);
        repeat (9) tick();
        chk("tmo_c10_err", merr, 0);
        chk("tmo_c10_cyc", scyc, 6'h10);
        tick();
        chk("tmo_err", merr, 1);
        chk("tmo_ack", mack, 0);
        chk("tmo_code", ecode, 2'b10);
        chk("tmo_eadr", eadr, 32'h2010);
        chk("tmo_cnt", ecnt, 2);
        chk("tmo_cyc", scyc, 0);
        idle_master();
        tick();

        // Ack on exactly the timeout cycle wins
        start(32'h3008, 1'b0);
        tick();
        chk("a10_cyc", scyc, 6'h20);
        repeat (9) tick();
        sack = 6'b100000;
        sdat_i[5*DW +: DW] = 32'hA5A50001;
        tick();
        chk("a10_ack", mack, 1);
        chk("a10_err", merr, 0);
        chk("a10_dat", mdat, 32'hA5A50001);
        chk("a10_cnt", ecnt, 2);
        sack = '0;
        idle_master();
        tick();

        // Overlap 0/3 at 0x40 and a spurious ack from slave 5
        start(32'h40, 1'b0);
        tick();
        chk("ovl_cyc", scyc, 6'h01);
        chk("ovl_adr", sadr, 32'h40);
        sack = 6'b100000;
        tick();
        chk("spur_ack", mack, 0);
        chk("spur_cyc", scyc, 6'h01);
        sack = 6'b000001;
        sdat_i[0 +: DW] = 32'h0000CAFE;
        tick();
        chk("ovl_ack", mack, 1);
        chk("ovl_dat", mdat, 32'h0000CAFE);
        sack = '0;
        idle_master();
        tick();

        // Reset in the middle of WAIT
        start(32'h104, 1'b0);
        tick();
        tick();
        chk("rw_cyc", scyc, 6'h04);
        rst = 1'b1;
        #1;
        chk("rw_cyc_drop", scyc, 0);
        chk("rw_cnt", ecnt, 0);
        tick();
        chk("rw_ack", mack, 0);
        chk("rw_err", merr, 0);
        rst = 1'b0;
        idle_master();
        tick();

        // Master abort in WAIT, then a normal transfer
        start(32'h1100, 1'b0);
        tick();
        chk("ab_cyc", scyc, 6'h02);
        idle_master();
        tick();
        chk("ab_cyc_drop", scyc, 0);
        chk("ab_ack", mack, 0);
        chk("ab_err", merr, 0);
        tick();
        chk("ab_ack2", mack, 0);
        chk("ab_err2", merr, 0);
        start(32'h1100, 1'b0);
        tick();
        chk("ab_nx_cyc", scyc, 6'h02);
        chk("ab_nx_adr", sadr, 32'h100);
        sack = 6'b000010;
        sdat_i[1*DW +: DW] = 32'h11112222;
        tick();
        chk("ab_nx_ack", mack, 1);
        chk("ab_nx_dat", mdat, 32'h11112222);
        sack = '0;
        idle_master();
        tick();

        // Saturate the error counter with back-to-back misses
        start(32'hFFFF0000, 1'b0);
        for (int i = 0; i < 65540 * 2; i++) tick();
        idle_master();
        tick();
        chk("sat_cnt", ecnt, 16'hFFFF);
        chk("sat_code", ecode, 2'b01);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cnt", ecnt, 0);
        chk("clr_code", ecode, 0);
        chk("clr_eadr", eadr, 0);

        // Clear coincident with a new error
        start(32'hFFFF0000, 1'b0);
        tick();
        chk("pre_cnt", ecnt, 1);
        idle_master();
        tick();
        clr = 1'b1;
        start(32'h8000, 1'b0);
        tick();
        clr = 1'b0;
        idle_master();
        chk("coin_err", merr, 1);
        chk("coin_cnt", ecnt, 1);
        chk("coin_code", ecode, 2'b01);
        chk("coin_eadr", eadr, 32'h8000);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
